// File: rtl/ksa_engine_if.sv
// RC4 key-schedule engine bus: host request/done handshake plus S-memory port.
interface ksa_engine_if;
    logic        start_task2;
    logic [23:0] secret_key;
    logic        task2_done;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic [7:0]  s_q;

    modport master (
        input  start_task2, secret_key, s_q,
        output task2_done, s_address, s_data, s_wren
    );

    modport slave (
        output start_task2, secret_key, s_q,
        input  task2_done, s_address, s_data, s_wren
    );
endinterface

// File: rtl/ksa_engine.sv
// RC4 key scheduling over an external 256-byte S memory (2-cycle read latency).
// Optional KSA_SELF_SWAP_SKIP_EN: skip the read/swap of S[j] when j == i.
//
// state  | meaning
// IDLE   | waiting for start_task2, key latched on exit
// RD_I   | s_address = i presented
// WAIT_I | address held while memory read completes
// CAP_I  | si <= s_q, j updated
// RD_J   | s_address = j presented
// WAIT_J | address held while memory read completes
// CAP_J  | sj <= s_q
// WR_I   | S[i] <= sj
// WR_J   | S[j] <= si, advance i or finish
// DONE   | task2_done held until start_task2 drops
module ksa_engine (
    input  logic         clk,
    input  logic         reset,
    ksa_engine_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_I, WR_J, DONE
    } state_t;

    state_t      state;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [1:0]  k;
    logic [23:0] key;
    logic [7:0]  si;
    logic [7:0]  key_byte;
    logic [7:0]  j_next;

    always_comb begin
        key_byte = key[7:0];
        case (k)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
        j_next = j + bus.s_q + key_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            i              <= 8'd0;
            j              <= 8'd0;
            k              <= 2'd0;
            key            <= 24'd0;
            si             <= 8'd0;
            bus.s_address  <= 8'd0;
            bus.s_data     <= 8'd0;
            bus.s_wren     <= 1'b0;
            bus.task2_done <= 1'b0;
        end else begin
            bus.s_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_task2) begin
                        key           <= bus.secret_key;
                        i             <= 8'd0;
                        j             <= 8'd0;
                        k             <= 2'd0;
                        bus.s_address <= 8'd0;
                        state         <= RD_I;
                    end
                end
                RD_I:   state <= WAIT_I;
                WAIT_I: state <= CAP_I;
                CAP_I: begin
                    si <= bus.s_q;
                    j  <= j_next;
`ifdef KSA_SELF_SWAP_SKIP_EN
                    // S[i] and S[j] are the same cell, the swap is a no-op
                    if (j_next == i) begin
                        if (i == 8'hFF) begin
                            bus.task2_done <= 1'b1;
                            state          <= DONE;
                        end else begin
                            i             <= i + 8'd1;
                            k             <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                            bus.s_address <= i + 8'd1;
                            state         <= RD_I;
                        end
                    end else begin
                        bus.s_address <= j_next;
                        state         <= RD_J;
                    end
`else
                    bus.s_address <= j_next;
                    state         <= RD_J;
`endif
                end
                RD_J:   state <= WAIT_J;
                WAIT_J: state <= CAP_J;
                CAP_J: begin
                    bus.s_address <= i;
                    bus.s_data    <= bus.s_q;
                    bus.s_wren    <= 1'b1;
                    state         <= WR_I;
                end
                WR_I: begin
                    bus.s_address <= j;
                    bus.s_data    <= si;
                    bus.s_wren    <= 1'b1;
                    state         <= WR_J;
                end
                WR_J: begin
                    if (i == 8'hFF) begin
                        bus.task2_done <= 1'b1;
                        state          <= DONE;
                    end else begin
                        i             <= i + 8'd1;
                        k             <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                        bus.s_address <= i + 8'd1;
                        state         <= RD_I;
                    end
                end
                DONE: begin
                    if (!bus.start_task2) begin
                        bus.task2_done <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ksa_engine.sv
// Self-checking bench for ksa_engine: directed key vectors against a software KSA model.
module tb_ksa_engine;
    logic clk;
    logic reset;

    ksa_engine_if bus ();

    ksa_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S memory: registered address, registered data (two-edge read latency)
    logic [7:0]  mem [256];
    logic [7:0]  model_s [256];
    logic [7:0]  addr_q;
    logic [15:0] wlog [$];

    always @(posedge clk) begin
        addr_q  <= bus.s_address;
        bus.s_q <= mem[addr_q];
        if (bus.s_wren) begin
            mem[bus.s_address] <= bus.s_data;
            wlog.push_back({bus.s_address, bus.s_data});
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic init_identity();
        for (int n = 0; n < 256; n++) mem[n] = n[7:0];
    endtask

    // Reference RC4 KSA run over model_s, which holds the starting S contents
    task automatic ksa_model(input logic [23:0] k);
        logic [7:0] jj, t, kb;
        jj = 8'd0;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            jj = jj + model_s[n] + kb;
            t = model_s[n];
            model_s[n] = model_s[jj];
            model_s[jj] = t;
        end
    endtask

    task automatic snapshot_model(input logic [23:0] k);
        for (int n = 0; n < 256; n++) model_s[n] = mem[n];
        ksa_model(k);
    endtask

    task automatic check_final_s(input string name);
        int bad;
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== model_s[n]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic run_ksa(input logic [23:0] k, input bit toggle, input int hold,
                           output int cycles);
        int low_seen;
        wlog.delete();
        @(negedge clk);
        bus.secret_key  = k;
        bus.start_task2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (toggle) bus.secret_key = ~k;
        cycles = 0;
        while (cycles < 5000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.task2_done) break;
        end
        chk("done_seen", bus.task2_done, 1);
        low_seen = 0;
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            if (!bus.task2_done) low_seen++;
        end
        if (hold > 0) chk("done_held", low_seen, 0);
        bus.start_task2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_drop", bus.task2_done, 0);
    endtask

    typedef struct {
        logic [23:0] key;
        logic [7:0]  a0, d0, a1, d1;
        bit          toggle;
        int          hold;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cycles;

        vecs[0] = '{key: 24'h010203, a0: 8'h00, d0: 8'h01, a1: 8'h01, d1: 8'h00, toggle: 1'b0, hold: 0};
        vecs[1] = '{key: 24'hFFFFFF, a0: 8'h00, d0: 8'hFF, a1: 8'hFF, d1: 8'h00, toggle: 1'b0, hold: 10};
        vecs[2] = '{key: 24'h000000, a0: 8'h00, d0: 8'h00, a1: 8'h00, d1: 8'h00, toggle: 1'b0, hold: 0};
        vecs[3] = '{key: 24'h123456, a0: 8'h00, d0: 8'h12, a1: 8'h12, d1: 8'h00, toggle: 1'b1, hold: 3};

        reset           = 1'b0;
        bus.start_task2 = 1'b0;
        bus.secret_key  = 24'd0;
        init_identity();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", bus.s_address, 0);
        chk("rst_data", bus.s_data, 0);
        chk("rst_wren", bus.s_wren, 0);
        chk("rst_done", bus.task2_done, 0);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            init_identity();
            snapshot_model(vecs[v].key);
            run_ksa(vecs[v].key, vecs[v].toggle, vecs[v].hold, cycles);
            check_final_s("final_s");
`ifndef KSA_SELF_SWAP_SKIP_EN
            chk("done_edge", cycles, 2048);
            chk("wr_count", wlog.size(), 512);
            if (wlog.size() >= 2) begin
                chk("it0_wr_i_addr", wlog[0][15:8], vecs[v].a0);
                chk("it0_wr_i_data", wlog[0][7:0],  vecs[v].d0);
                chk("it0_wr_j_addr", wlog[1][15:8], vecs[v].a1);
                chk("it0_wr_j_data", wlog[1][7:0],  vecs[v].d1);
            end else begin
                chk("it0_writes_present", wlog.size(), 512);
            end
            // key FFFFFF: i=1 gives j = FF + 1 + FF = FF again
            if (v == 1 && wlog.size() >= 4) begin
                chk("ff_it1_wr_i", wlog[2], 16'h0100);
                chk("ff_it1_wr_j", wlog[3], 16'hFF01);
            end
`else
            // key 000000: iterations 0 and 1 have j == i, first write is from i=2 (j=3)
            if (v == 2 && wlog.size() >= 1) chk("skip_first_wr", wlog[0], 16'h0203);
`endif
        end

        // reset in the middle of a run, then restart from the partially permuted S
        init_identity();
        wlog.delete();
        @(negedge clk);
        bus.secret_key  = 24'h123456;
        bus.start_task2 = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset           = 1'b0;
        bus.start_task2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_addr", bus.s_address, 0);
        chk("mid_rst_data", bus.s_data, 0);
        chk("mid_rst_wren", bus.s_wren, 0);
        chk("mid_rst_done", bus.task2_done, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst_wren", bus.s_wren, 0);
        chk("idle_after_rst_done", bus.task2_done, 0);
        snapshot_model(24'hA5C3E7);
        run_ksa(24'hA5C3E7, 1'b0, 0, cycles);
        check_final_s("restart_final_s");
`ifndef KSA_SELF_SWAP_SKIP_EN
        chk("restart_done_edge", cycles, 2048);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ksa_engine.md
KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low; reset=0 sampled on a rising edge resets the block.
REQ-003 start_task2  input  1  level request to run key scheduling over S memory.
REQ-004 secret_key  input  24  RC4 key; byte0=[23:16], byte1=[15:8], byte2=[7:0].
REQ-005 s_q  input  8  S memory read data; valid on the second rising edge after s_address is driven.
REQ-006 s_address  output  8  S memory address.
REQ-007 s_data  output  8  S memory write data.
REQ-008 s_wren  output  1  S memory write enable; one-cycle pulses only.
REQ-009 task2_done  output  1  high when all 256 swaps have completed.

Function
REQ-010 Per iteration i=0..255, the block shall compute j = (j + S[i] + key[i mod 3]) mod 256, then swap S[i] and S[j]; j starts at 0.
REQ-011 States: IDLE, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_I, WR_J, DONE.
- IDLE -> RD_I on start_task2=1; latch secret_key; i=0, j=0, mod-3 counter=0.
- RD_I: s_address=i. WAIT_I: hold address. CAP_I: latch si=s_q; update j.
- RD_J: s_address=j. WAIT_J: hold. CAP_J: latch sj=s_q.
- WR_I: s_address=i, s_data=sj, s_wren=1. WR_J: s_address=j, s_data=si, s_wren=1.
- WR_J -> DONE if i=255, else i+1, mod-3 counter advances (2 wraps to 0), -> RD_I.
REQ-012 Key byte selection shall use a mod-3 counter; no divider.
REQ-013 All j and i arithmetic is 8-bit and wraps modulo 256 without flags.
REQ-014 Without KSA_SELF_SWAP_SKIP_EN, each iteration shall take exactly 8 cycles; task2_done shall rise on the 2048th rising edge after the edge that sampled start_task2.
REQ-015 s_wren shall be 0 in every state except WR_I and WR_J.
REQ-016 DONE: task2_done=1 while start_task2=1; start_task2=0 -> IDLE, task2_done=0 on the next edge.
REQ-017 start_task2 changes and secret_key changes outside IDLE shall be ignored.
REQ-018 When i=j, both writes shall still occur with identical data (memory unchanged).

Reset
REQ-019 reset=0 shall force IDLE, i=0, j=0, s_address=0, s_data=0, s_wren=0, task2_done=0 on that edge, from any state.
REQ-020 Reset mid-run shall leave S memory partially permuted; there is no restore, and the next start restarts from i=0.

Configuration
REQ-021 KSA_SELF_SWAP_SKIP_EN defined: if the j computed in CAP_I equals i, skip RD_J through WR_J and advance directly (3-cycle iteration, no s_wren pulse).
REQ-022 KSA_SELF_SWAP_SKIP_EN undefined: always take the full 8-cycle iteration per REQ-014 and REQ-018.

Verification
REQ-023 Identity S, key 24'h010203, macro off -> iteration 0: WR_I addr 0x00 data 0x01, WR_J addr 0x01 data 0x00; task2_done at edge 2048; final S matches the software KSA model.
REQ-024 Identity S, key 24'hFFFFFF -> i=0: j=0xFF (writes addr 0x00 data 0xFF, addr 0xFF data 0x00); i=1: j wraps to 0xFF.
REQ-025 reset=0 on cycle 100 of a run -> all outputs 0 on that edge, IDLE; restart with start_task2=1 completes in 2048 cycles.
REQ-026 Hold start_task2=1 for 10 cycles after done -> task2_done stays 1; drop it -> task2_done=0 on the next edge; secret_key toggled mid-run -> result unchanged.
REQ-027 Identity S, key 24'h000000, macro on -> iteration 0 (j=0) shows no s_wren pulse and lasts 3 cycles; macro off -> two s_wren pulses, addr 0x00 data 0x00.
